// File: rtl/opcode_sequencer_pkg.sv
// Shared encodings for the 6502 load/store sequencer: states, modes, opcode groups,
// write-enable bit positions and source-select codes. Indirect modes gated by INDIRECT_MODES_EN.
// Pure definitions; no timing or flow control here.
package opcode_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DECODE, ST_FETCH_LO, ST_FETCH_HI, ST_PTR_LO,
    ST_PTR_HI, ST_INDEX, ST_FIX, ST_EXEC, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    MODE_IMM, MODE_ZP, MODE_ZP_IDX, MODE_ABS, MODE_ABS_IDX, MODE_IND_X, MODE_IND_Y
  } mode_e;

  typedef enum logic [1:0] {DST_ACC, DST_X, DST_Y} dst_e;

  localparam logic [1:0] CC_Y   = 2'b00;
  localparam logic [1:0] CC_ACC = 2'b01;
  localparam logic [1:0] CC_X   = 2'b10;

  localparam logic [2:0] AAA_STORE = 3'b100;
  localparam logic [2:0] AAA_LOAD  = 3'b101;

  // Opcode groups keyed by {aaa, cc}
  localparam logic [4:0] GRP_LDA = {AAA_LOAD,  CC_ACC};
  localparam logic [4:0] GRP_STA = {AAA_STORE, CC_ACC};
  localparam logic [4:0] GRP_LDX = {AAA_LOAD,  CC_X};
  localparam logic [4:0] GRP_STX = {AAA_STORE, CC_X};
  localparam logic [4:0] GRP_LDY = {AAA_LOAD,  CC_Y};
  localparam logic [4:0] GRP_STY = {AAA_STORE, CC_Y};

  // bbb modes for cc=01
  localparam logic [2:0] BBB_A_IND_X  = 3'b000;
  localparam logic [2:0] BBB_A_ZP     = 3'b001;
  localparam logic [2:0] BBB_A_IMM    = 3'b010;
  localparam logic [2:0] BBB_A_ABS    = 3'b011;
  localparam logic [2:0] BBB_A_IND_Y  = 3'b100;
  localparam logic [2:0] BBB_A_ZP_X   = 3'b101;
  localparam logic [2:0] BBB_A_ABS_Y  = 3'b110;
  localparam logic [2:0] BBB_A_ABS_X  = 3'b111;

  // bbb modes for cc=00/10
  localparam logic [2:0] BBB_XY_IMM     = 3'b000;
  localparam logic [2:0] BBB_XY_ZP      = 3'b001;
  localparam logic [2:0] BBB_XY_ABS     = 3'b011;
  localparam logic [2:0] BBB_XY_ZP_IDX  = 3'b101;
  localparam logic [2:0] BBB_XY_ABS_IDX = 3'b111;

  localparam int WE_ACC = 0;
  localparam int WE_X   = 1;
  localparam int WE_Y   = 2;
  localparam int WE_MEM = 3;

  localparam int SEL_IMM = 1;
  localparam int SEL_MEM = 2;
  localparam int SEL_ACC = 3;
  localparam int SEL_X   = 4;
  localparam int SEL_Y   = 5;

`ifdef INDIRECT_MODES_EN
  localparam bit INDIRECT_EN = 1'b1;
`else
  localparam bit INDIRECT_EN = 1'b0;
`endif

endpackage

// File: rtl/opcode_sequencer_addr_mode_decode.sv
// addr_mode_decode: opcode byte to addressing mode, index register, direction, destination, legality.
// Latency: combinational.
// Backpressure: none.
module addr_mode_decode
  import opcode_sequencer_pkg::*;
#(
  parameter int REG_WIDTH = 8
) (
  input  logic [REG_WIDTH-1:0] opcode,
  output mode_e                mode,
  output logic                 index_is_y,
  output logic                 is_store,
  output dst_e                 dst,
  output logic                 legal
);

  logic [2:0] bbb;
  logic [4:0] grp;

  assign bbb = opcode[4:2];
  assign grp = {opcode[7:5], opcode[1:0]};

  always_comb begin
    mode       = MODE_IMM;
    index_is_y = 1'b0;
    is_store   = 1'b0;
    dst        = DST_ACC;
    legal      = 1'b0;
    case (grp)
      GRP_LDA, GRP_STA: begin
        legal    = 1'b1;
        is_store = (grp == GRP_STA);
        case (bbb)
          BBB_A_IND_X: begin mode = MODE_IND_X; legal = INDIRECT_EN; end
          BBB_A_ZP:    mode = MODE_ZP;
          BBB_A_IMM:   mode = MODE_IMM;
          BBB_A_ABS:   mode = MODE_ABS;
          BBB_A_IND_Y: begin mode = MODE_IND_Y; index_is_y = 1'b1; legal = INDIRECT_EN; end
          BBB_A_ZP_X:  mode = MODE_ZP_IDX;
          BBB_A_ABS_Y: begin mode = MODE_ABS_IDX; index_is_y = 1'b1; end
          BBB_A_ABS_X: mode = MODE_ABS_IDX;
          default:     legal = 1'b0;
        endcase
      end
      GRP_LDX, GRP_STX, GRP_LDY, GRP_STY: begin
        legal      = 1'b1;
        is_store   = (grp == GRP_STX) || (grp == GRP_STY);
        dst        = ((grp == GRP_LDX) || (grp == GRP_STX)) ? DST_X : DST_Y;
        index_is_y = ((grp == GRP_LDX) || (grp == GRP_STX));
        case (bbb)
          BBB_XY_IMM:     mode = MODE_IMM;
          BBB_XY_ZP:      mode = MODE_ZP;
          BBB_XY_ABS:     mode = MODE_ABS;
          BBB_XY_ZP_IDX:  mode = MODE_ZP_IDX;
          BBB_XY_ABS_IDX: mode = MODE_ABS_IDX;
          default:        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Stores have no immediate form, and STX abs,Y / STY abs,X do not exist.
    if (is_store && ((mode == MODE_IMM) || ((dst != DST_ACC) && (mode == MODE_ABS_IDX))))
      legal = 1'b0;
  end

endmodule

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: 6502 LD/ST decode + addressing FSM; (zp,X)/(zp),Y under INDIRECT_MODES_EN.
// Latency: accept to done 4 (imm/zp), 5 (zp,idx/abs), 6 (abs,idx), +1 page cross, + operand stalls.
// Backpressure: waits in fetch states while op_valid is low; instr_ready low from accept until idle.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int WE_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  input  logic [REG_WIDTH-1:0]  instr_data,
  output logic                  instr_ready,
  output logic                  op_req,
  input  logic                  op_valid,
  input  logic [REG_WIDTH-1:0]  op_data,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic [ADDR_WIDTH-1:0] eff_addr,
  output logic [REG_WIDTH-1:0]  operand_out,
  output logic [WE_WIDTH-1:0]   we,
  output logic [SEL_WIDTH-1:0]  src_sel,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  page_cross,
  output logic                  done,
  output logic                  illegal
);

  typedef struct packed {
    logic [WE_WIDTH-1:0]  we;
    logic [SEL_WIDTH-1:0] src_sel;
    logic                 mem_rd;
    logic                 mem_wr;
  } ctl_t;

  state_e               state;
  logic [REG_WIDTH-1:0] opcode_q, lo_q, hi_q;
  mode_e                mode;
  dst_e                 dst;
  logic                 index_is_y, is_store, legal;
  ctl_t                 ctl_q, exec_ctl;
  logic [REG_WIDTH-1:0] idx, hi_inc;
  logic [REG_WIDTH:0]   idx_sum;

  addr_mode_decode #(.REG_WIDTH(REG_WIDTH)) u_decode (
    .opcode     (opcode_q),
    .mode       (mode),
    .index_is_y (index_is_y),
    .is_store   (is_store),
    .dst        (dst),
    .legal      (legal)
  );

  assign idx     = index_is_y ? y_in : x_in;
  assign idx_sum = {1'b0, lo_q} + {1'b0, idx};
  assign hi_inc  = hi_q + 1'b1;

`ifdef INDIRECT_MODES_EN
  logic [REG_WIDTH-1:0] ptr_q, ptr_addr, ptr_next;
  assign ptr_addr = (mode == MODE_IND_X) ? op_data + x_in : op_data;
  assign ptr_next = ptr_q + 1'b1;
`endif

  // Strobes for the single execute cycle, loaded into ctl_q on entry to ST_EXEC.
  always_comb begin
    exec_ctl = '0;
    if (is_store) begin
      exec_ctl.mem_wr         = 1'b1;
      exec_ctl.we[WE_MEM]     = 1'b1;
      case (dst)
        DST_X:   exec_ctl.src_sel = SEL_WIDTH'(SEL_X);
        DST_Y:   exec_ctl.src_sel = SEL_WIDTH'(SEL_Y);
        default: exec_ctl.src_sel = SEL_WIDTH'(SEL_ACC);
      endcase
    end else begin
      case (dst)
        DST_X:   exec_ctl.we[WE_X]   = 1'b1;
        DST_Y:   exec_ctl.we[WE_Y]   = 1'b1;
        default: exec_ctl.we[WE_ACC] = 1'b1;
      endcase
      if (mode == MODE_IMM) begin
        exec_ctl.src_sel = SEL_WIDTH'(SEL_IMM);
      end else begin
        exec_ctl.src_sel = SEL_WIDTH'(SEL_MEM);
        exec_ctl.mem_rd  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      op_req      <= 1'b0;
      eff_addr    <= '0;
      operand_out <= '0;
      page_cross  <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      ctl_q       <= '0;
      opcode_q    <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
`ifdef INDIRECT_MODES_EN
      ptr_q       <= '0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: if (instr_valid && instr_ready) begin
          opcode_q    <= instr_data;
          instr_ready <= 1'b0;
          eff_addr    <= '0;
          operand_out <= '0;
          page_cross  <= 1'b0;
          state       <= ST_DECODE;
        end
        ST_DECODE: if (legal) begin
          op_req <= 1'b1;
          state  <= ST_FETCH_LO;
        end else begin
          illegal     <= 1'b1;
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_FETCH_LO: if (op_valid) begin
          lo_q <= op_data;
          case (mode)
            MODE_IMM: begin
              operand_out <= op_data;
              op_req      <= 1'b0;
              ctl_q       <= exec_ctl;
              state       <= ST_EXEC;
            end
            MODE_ZP: begin
              eff_addr <= ADDR_WIDTH'(op_data);
              op_req   <= 1'b0;
              ctl_q    <= exec_ctl;
              state    <= ST_EXEC;
            end
            MODE_ZP_IDX: begin
              op_req <= 1'b0;
              state  <= ST_INDEX;
            end
`ifdef INDIRECT_MODES_EN
            MODE_IND_X, MODE_IND_Y: begin
              op_req       <= 1'b0;
              ptr_q        <= ptr_addr;
              eff_addr     <= ADDR_WIDTH'(ptr_addr);
              ctl_q.mem_rd <= 1'b1;
              state        <= ST_PTR_LO;
            end
`endif
            default: state <= ST_FETCH_HI;
          endcase
        end
        ST_FETCH_HI: if (op_valid) begin
          hi_q   <= op_data;
          op_req <= 1'b0;
          if (mode == MODE_ABS) begin
            eff_addr <= ADDR_WIDTH'({op_data, lo_q});
            ctl_q    <= exec_ctl;
            state    <= ST_EXEC;
          end else begin
            state <= ST_INDEX;
          end
        end
`ifdef INDIRECT_MODES_EN
        ST_PTR_LO: if (op_valid) begin
          lo_q     <= op_data;
          eff_addr <= ADDR_WIDTH'(ptr_next);
          state    <= ST_PTR_HI;
        end
        ST_PTR_HI: if (op_valid) begin
          hi_q <= op_data;
          if (mode == MODE_IND_Y) begin
            ctl_q <= '0;
            state <= ST_INDEX;
          end else begin
            eff_addr <= ADDR_WIDTH'({op_data, lo_q});
            ctl_q    <= exec_ctl;
            state    <= ST_EXEC;
          end
        end
`endif
        ST_INDEX: begin
          // Zero-page indexing wraps inside page zero; carry only matters for 16-bit bases.
          if (mode == MODE_ZP_IDX) begin
            eff_addr <= ADDR_WIDTH'(idx_sum[REG_WIDTH-1:0]);
            ctl_q    <= exec_ctl;
            state    <= ST_EXEC;
          end else begin
            eff_addr <= ADDR_WIDTH'({hi_q, idx_sum[REG_WIDTH-1:0]});
            if (idx_sum[REG_WIDTH]) begin
              page_cross <= 1'b1;
              state      <= ST_FIX;
            end else begin
              ctl_q <= exec_ctl;
              state <= ST_EXEC;
            end
          end
        end
        ST_FIX: begin
          eff_addr <= ADDR_WIDTH'({hi_inc, eff_addr[REG_WIDTH-1:0]});
          ctl_q    <= exec_ctl;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          ctl_q <= '0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          op_req      <= 1'b0;
          ctl_q       <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign we      = ctl_q.we;
  assign src_sel = ctl_q.src_sel;
  assign mem_rd  = ctl_q.mem_rd;
  assign mem_wr  = ctl_q.mem_wr;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Randomised + directed bench for opcode_sequencer against a table-driven 6502 LD/ST model.
module tb_opcode_sequencer;
  import opcode_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [7:0]  instr_data;
  logic        instr_ready;
  logic        op_req;
  logic        op_valid;
  logic [7:0]  op_data;
  logic [7:0]  x_in, y_in;
  logic [15:0] eff_addr;
  logic [7:0]  operand_out;
  logic [9:0]  we;
  logic [3:0]  src_sel;
  logic        mem_rd, mem_wr, page_cross, done, illegal;

  int n_cmp = 0;
  int n_err = 0;

  localparam int K_IMM = 0, K_ZP = 1, K_ZPI = 2, K_ABS = 3, K_ABSI = 4, K_IND = 5;

  typedef struct {
    bit legal;
    int kind;
    int rg;      // 0 = A, 1 = X, 2 = Y
    bit st;
    bit idx_y;
  } ref_t;

  opcode_sequencer #(
    .REG_WIDTH(8), .ADDR_WIDTH(16), .SEL_WIDTH(4), .WE_WIDTH(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .op_req(op_req), .op_valid(op_valid), .op_data(op_data),
    .x_in(x_in), .y_in(y_in),
    .eff_addr(eff_addr), .operand_out(operand_out), .we(we), .src_sel(src_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .page_cross(page_cross),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The documented 6502 LD/ST opcode table.
  function automatic ref_t ref_decode(input logic [7:0] op);
    ref_t r;
    r.legal = 1'b1;
    r.st    = (op[7:5] == 3'b100);
    r.idx_y = 1'b0;
    r.rg    = (op[1:0] == 2'b10) ? 1 : (op[1:0] == 2'b00) ? 2 : 0;
    case (op)
      8'hA9, 8'hA2, 8'hA0:                      r.kind = K_IMM;
      8'hA5, 8'h85, 8'hA6, 8'h86, 8'hA4, 8'h84: r.kind = K_ZP;
      8'hB5, 8'h95, 8'hB4, 8'h94:               r.kind = K_ZPI;
      8'hB6, 8'h96:                             begin r.kind = K_ZPI; r.idx_y = 1'b1; end
      8'hAD, 8'h8D, 8'hAE, 8'h8E, 8'hAC, 8'h8C: r.kind = K_ABS;
      8'hBD, 8'h9D, 8'hBC:                      r.kind = K_ABSI;
      8'hB9, 8'h99, 8'hBE:                      begin r.kind = K_ABSI; r.idx_y = 1'b1; end
      8'hA1, 8'h81, 8'hB1, 8'h91:               begin r.kind = K_IND; r.legal = 1'b0; end
      default:                                  begin r.kind = K_IMM; r.legal = 1'b0; end
    endcase
    return r;
  endfunction

  task automatic run_instr(input logic [7:0] op, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] xv, input logic [7:0] yv, input int st0, input int st1);
    ref_t d;
    int nb, idx, base, exp_ea, exp_pc, lat, exp_we, exp_sel;
    int cyc, end_cyc, n_done, n_ill, n_exec, n_rdy, bi, stall;
    bit fin, rdy_end;
    logic [9:0]  ex_we;
    logic [3:0]  ex_sel;
    logic        ex_rd, ex_wr, ex_pc;
    logic [15:0] ex_ea;
    logic [7:0]  ex_opnd;

    d      = ref_decode(op);
    nb     = (d.kind == K_ABS || d.kind == K_ABSI) ? 2 : 1;
    idx    = d.idx_y ? int'(yv) : int'(xv);
    base   = (nb == 2) ? int'(b1) * 256 + int'(b0) : int'(b0);
    exp_pc = 0;
    case (d.kind)
      K_ZPI:   exp_ea = (int'(b0) + idx) % 256;
      K_ABSI:  begin exp_ea = (base + idx) % 65536; exp_pc = (int'(b0) + idx > 255) ? 1 : 0; end
      default: exp_ea = base;
    endcase
    case (d.kind)
      K_IMM, K_ZP:  lat = 4;
      K_ZPI, K_ABS: lat = 5;
      default:      lat = 6 + exp_pc;
    endcase
    lat     = lat + st0 + ((nb == 2) ? st1 : 0);
    exp_we  = d.st ? (1 << WE_MEM) : (1 << ((d.rg == 0) ? WE_ACC : (d.rg == 1) ? WE_X : WE_Y));
    exp_sel = d.st ? ((d.rg == 0) ? SEL_ACC : (d.rg == 1) ? SEL_X : SEL_Y)
                   : ((d.kind == K_IMM) ? SEL_IMM : SEL_MEM);

    @(negedge clk);
    x_in = xv; y_in = yv;
    instr_data = op; instr_valid = 1'b1;
    check_val("rdy_idle", instr_ready, 1);

    cyc = 0; fin = 0; end_cyc = 0; n_done = 0; n_ill = 0; n_exec = 0; n_rdy = 0;
    bi = 0; stall = st0; rdy_end = 0;
    ex_we = '0; ex_sel = '0; ex_rd = 0; ex_wr = 0; ex_pc = 0; ex_ea = '0; ex_opnd = '0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
      if (done) n_done++;
      if (illegal) n_ill++;
      if (instr_ready && !(done || illegal)) n_rdy++;
      if (we != '0 || mem_rd || mem_wr) begin
        n_exec++;
        ex_we = we; ex_sel = src_sel; ex_rd = mem_rd; ex_wr = mem_wr;
        ex_ea = eff_addr; ex_pc = page_cross; ex_opnd = operand_out;
      end
      if (done || illegal) begin
        fin = 1; end_cyc = cyc; rdy_end = instr_ready;
      end
      op_valid = 1'b0;
      op_data  = 8'($urandom);
      if (op_req && !fin) begin
        if (stall > 0) stall--;
        else begin
          op_valid = 1'b1;
          op_data  = (bi == 0) ? b0 : b1;
          bi++;
          stall = st1;
        end
      end
    end
    op_valid = 1'b0;

    check_val("finished", fin, 1);
    check_val("done_cnt", n_done, d.legal ? 1 : 0);
    check_val("illegal_cnt", n_ill, d.legal ? 0 : 1);
    check_val("exec_cnt", n_exec, d.legal ? 1 : 0);
    check_val("end_cycle", end_cyc, d.legal ? lat : 2);
    check_val("rdy_busy", n_rdy, 0);
    check_val("rdy_end", rdy_end, d.legal ? 0 : 1);
    if (d.legal) begin
      check_val("we", ex_we, exp_we);
      check_val("src_sel", ex_sel, exp_sel);
      check_val("mem_rd", ex_rd, (!d.st && d.kind != K_IMM) ? 1 : 0);
      check_val("mem_wr", ex_wr, d.st ? 1 : 0);
      if (d.kind == K_IMM) check_val("operand_out", ex_opnd, b0);
      else begin
        check_val("eff_addr", ex_ea, exp_ea);
        check_val("page_cross", ex_pc, exp_pc);
      end
    end
    @(negedge clk);
    check_val("rdy_after", instr_ready, 1);
    check_val("pulse_clear", {done, illegal}, 0);
  endtask

  initial begin
    logic [7:0] op;
    ref_t       d;
    int         acc;

    reset_n = 1'b0; instr_valid = 1'b0; instr_data = '0;
    op_valid = 1'b0; op_data = '0; x_in = '0; y_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_rdy", instr_ready, 1);
    check_val("rst_strobes", {op_req, mem_rd, mem_wr, done, illegal, page_cross}, 0);
    check_val("rst_we", we, 0);
    check_val("rst_ea", eff_addr, 0);
    reset_n = 1'b1;

    run_instr(8'hA9, 8'h42, 8'h00, 8'h00, 8'h00, 0, 0);
    run_instr(8'hB5, 8'h12, 8'h00, 8'hF0, 8'h00, 0, 0);
    run_instr(8'hBD, 8'hFF, 8'h12, 8'h01, 8'h00, 0, 0);
    run_instr(8'hBD, 8'hFF, 8'h12, 8'h00, 8'h00, 0, 0);
    run_instr(8'hBD, 8'hFF, 8'hFF, 8'h01, 8'h00, 0, 0);
    run_instr(8'h96, 8'h10, 8'h00, 8'h00, 8'h05, 3, 0);
    run_instr(8'h89, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    run_instr(8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

    // Reset while waiting for the high address byte.
    @(negedge clk);
    instr_data = 8'hAD; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check_val("ad_req_lo", op_req, 1);
    op_valid = 1'b1; op_data = 8'h34;
    @(negedge clk);
    op_valid = 1'b0;
    check_val("ad_req_hi", op_req, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_val("abort_rdy", instr_ready, 1);
    check_val("abort_strobes", {op_req, mem_rd, mem_wr, done, illegal, page_cross}, 0);
    check_val("abort_we", we, 0);
    check_val("abort_ea", eff_addr, 0);
    acc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || illegal || mem_rd || mem_wr || we != '0 || op_req) acc++;
    end
    check_val("abort_quiet", acc, 0);
    run_instr(8'hA9, 8'h07, 8'h00, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = {2'b10, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2))};
      d = ref_decode(op);
`ifdef INDIRECT_MODES_EN
      if (d.kind == K_IND) continue;
`endif
      run_instr(op, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
